// File: rtl/scoreboard.sv
// In-order circular instruction buffer between decode and issue.
// Tracks each entry through allocate, issue, writeback and commit, and exports a forwarding view.
module scoreboard #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned IDX_W      = $clog2(NR_ENTRIES),
  parameter int unsigned XLEN       = 64,
  parameter int unsigned PAYLOAD_W  = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       decoded_valid_i,
  input  logic [PAYLOAD_W-1:0]       decoded_payload_i,
  input  logic [4:0]                 decoded_rd_i,
  input  logic                       decoded_ex_i,
  output logic                       decoded_ack_o,
  output logic                       issue_valid_o,
  output logic [PAYLOAD_W-1:0]       issue_payload_o,
  output logic                       issue_ex_o,
  input  logic                       issue_ack_i,
  output logic [IDX_W-1:0]           issue_pointer_o,
  output logic [NR_ENTRIES*5-1:0]    sb_rd_o,
  output logic [NR_ENTRIES-1:0]      sb_still_issued_o,
  output logic [NR_ENTRIES-1:0]      sb_res_valid_o,
  output logic [NR_ENTRIES*XLEN-1:0] sb_result_o,
  input  logic                       wb_valid_i,
  input  logic [IDX_W-1:0]           wb_idx_i,
  input  logic [XLEN-1:0]            wb_data_i,
  input  logic                       wb_ex_i,
  output logic                       commit_valid_o,
  output logic [IDX_W-1:0]           commit_idx_o,
  output logic [PAYLOAD_W-1:0]       commit_payload_o,
  output logic [4:0]                 commit_rd_o,
  output logic [XLEN-1:0]            commit_result_o,
  output logic                       commit_ex_o,
  input  logic                       commit_ack_i
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ALLOC  = 2'd1,
    ISSUED = 2'd2,
    DONE   = 2'd3
  } entry_state_e;

  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(NR_ENTRIES);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

  entry_state_e         state_q [NR_ENTRIES];
  entry_state_e         state_d [NR_ENTRIES];
  logic [PAYLOAD_W-1:0] payload_q [NR_ENTRIES];
  logic [4:0]           rd_q [NR_ENTRIES];
  logic                 ex_q [NR_ENTRIES];
  logic [XLEN-1:0]      result_q [NR_ENTRIES];

  logic [IDX_W-1:0] wr_ptr_q, iss_ptr_q, cmt_ptr_q;
  logic [IDX_W:0]   cnt_q;

  logic alloc, issue_fire, wb_fire, commit_fire;

  // Handshakes use registered state only, so there is no same-cycle free-slot bypass.
  assign decoded_ack_o  = decoded_valid_i && (cnt_q != CNT_FULL) && !flush_i;
  assign alloc          = decoded_ack_o;
  assign issue_valid_o  = (state_q[iss_ptr_q] == ALLOC);
  assign issue_fire     = issue_valid_o && issue_ack_i && !flush_i;
  assign wb_fire        = wb_valid_i && (state_q[wb_idx_i] == ISSUED) && !flush_i;
  assign commit_valid_o = (state_q[cmt_ptr_q] == DONE);
  assign commit_fire    = commit_valid_o && commit_ack_i && !flush_i;

  // Each event targets an entry in a distinct state, so the updates never collide.
  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      state_d[i] = state_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        state_d[i] = FREE;
      end
    end else begin
      if (alloc)       state_d[wr_ptr_q]  = ALLOC;
      if (issue_fire)  state_d[iss_ptr_q] = ex_q[iss_ptr_q] ? DONE : ISSUED;
      if (wb_fire)     state_d[wb_idx_i]  = DONE;
      if (commit_fire) state_d[cmt_ptr_q] = FREE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        state_q[i] <= FREE;
      end
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        payload_q[i] <= '0;
        rd_q[i]      <= '0;
        ex_q[i]      <= 1'b0;
        result_q[i]  <= '0;
      end
    end else if (!flush_i) begin
      if (alloc) begin
        payload_q[wr_ptr_q] <= decoded_payload_i;
        rd_q[wr_ptr_q]      <= decoded_rd_i;
        ex_q[wr_ptr_q]      <= decoded_ex_i;
        result_q[wr_ptr_q]  <= '0;
      end
      if (wb_fire) begin
        result_q[wb_idx_i] <= wb_data_i;
        ex_q[wb_idx_i]     <= ex_q[wb_idx_i] | wb_ex_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      iss_ptr_q <= '0;
      cmt_ptr_q <= '0;
      cnt_q     <= '0;
    end else if (flush_i) begin
      wr_ptr_q  <= '0;
      iss_ptr_q <= '0;
      cmt_ptr_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (alloc)       wr_ptr_q  <= wr_ptr_q + PTR_ONE;
      if (issue_fire)  iss_ptr_q <= iss_ptr_q + PTR_ONE;
      if (commit_fire) cmt_ptr_q <= cmt_ptr_q + PTR_ONE;
      case ({alloc, commit_fire})
        2'b10:   cnt_q <= cnt_q + (IDX_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (IDX_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign issue_pointer_o  = iss_ptr_q;
  assign issue_payload_o  = payload_q[iss_ptr_q];
  assign issue_ex_o       = ex_q[iss_ptr_q];

  assign commit_idx_o     = cmt_ptr_q;
  assign commit_payload_o = payload_q[cmt_ptr_q];
  assign commit_rd_o      = rd_q[cmt_ptr_q];
  assign commit_result_o  = result_q[cmt_ptr_q];
  assign commit_ex_o      = ex_q[cmt_ptr_q];

  // x0 never produces a value, so it is never reported as a pending destination.
  always_comb begin
    sb_rd_o           = '0;
    sb_still_issued_o = '0;
    sb_res_valid_o    = '0;
    sb_result_o       = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      sb_rd_o[i*5 +: 5]         = rd_q[i];
      sb_still_issued_o[i]      = ((state_q[i] == ISSUED) || (state_q[i] == DONE)) && (rd_q[i] != 5'd0);
      sb_res_valid_o[i]         = (state_q[i] == DONE);
      sb_result_o[i*XLEN +: XLEN] = result_q[i];
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: allocation, issue, writeback, in-order commit, full, flush, reset.
module tb_scoreboard;

  localparam int NR = 8;
  localparam int IW = 3;
  localparam int XL = 64;
  localparam int PW = 128;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            decoded_valid_i;
  logic [PW-1:0]   decoded_payload_i;
  logic [4:0]      decoded_rd_i;
  logic            decoded_ex_i;
  logic            decoded_ack_o;
  logic            issue_valid_o;
  logic [PW-1:0]   issue_payload_o;
  logic            issue_ex_o;
  logic            issue_ack_i;
  logic [IW-1:0]   issue_pointer_o;
  logic [NR*5-1:0] sb_rd_o;
  logic [NR-1:0]   sb_still_issued_o;
  logic [NR-1:0]   sb_res_valid_o;
  logic [NR*XL-1:0] sb_result_o;
  logic            wb_valid_i;
  logic [IW-1:0]   wb_idx_i;
  logic [XL-1:0]   wb_data_i;
  logic            wb_ex_i;
  logic            commit_valid_o;
  logic [IW-1:0]   commit_idx_o;
  logic [PW-1:0]   commit_payload_o;
  logic [4:0]      commit_rd_o;
  logic [XL-1:0]   commit_result_o;
  logic            commit_ex_o;
  logic            commit_ack_i;

  int n_vec = 0;
  int n_err = 0;

  scoreboard #(.NR_ENTRIES(NR), .XLEN(XL), .PAYLOAD_W(PW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .decoded_valid_i(decoded_valid_i), .decoded_payload_i(decoded_payload_i),
    .decoded_rd_i(decoded_rd_i), .decoded_ex_i(decoded_ex_i), .decoded_ack_o(decoded_ack_o),
    .issue_valid_o(issue_valid_o), .issue_payload_o(issue_payload_o), .issue_ex_o(issue_ex_o),
    .issue_ack_i(issue_ack_i), .issue_pointer_o(issue_pointer_o),
    .sb_rd_o(sb_rd_o), .sb_still_issued_o(sb_still_issued_o),
    .sb_res_valid_o(sb_res_valid_o), .sb_result_o(sb_result_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_data_i(wb_data_i), .wb_ex_i(wb_ex_i),
    .commit_valid_o(commit_valid_o), .commit_idx_o(commit_idx_o),
    .commit_payload_o(commit_payload_o), .commit_rd_o(commit_rd_o),
    .commit_result_o(commit_result_o), .commit_ex_o(commit_ex_o), .commit_ack_i(commit_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; decoded_valid_i = 0; decoded_payload_i = '0; decoded_rd_i = '0;
    decoded_ex_i = 0; issue_ack_i = 0; wb_valid_i = 0; wb_idx_i = '0; wb_data_i = '0;
    wb_ex_i = 0; commit_ack_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 0;
    step();
    rst_ni = 1;
    step();
  endtask

  initial begin
    idle();
    rst_ni = 0;
    #2;
    check_eq("rst_issue_valid", issue_valid_o, 0);
    check_eq("rst_commit_valid", commit_valid_o, 0);
    check_eq("rst_still_issued", sb_still_issued_o, 0);
    check_eq("rst_res_valid", sb_res_valid_o, 0);
    check_eq("rst_rd", sb_rd_o, 0);
    check_eq("rst_commit_idx", commit_idx_o, 0);
    rst_ni = 1;
    step();

    // allocate, issue, writeback, commit a single instruction
    decoded_valid_i = 1; decoded_rd_i = 5; decoded_payload_i = 128'h1234_5678;
    #1 check_eq("t1_ack", decoded_ack_o, 1);
    step();
    idle();
    check_eq("t1_issue_valid", issue_valid_o, 1);
    check_eq("t1_issue_ptr", issue_pointer_o, 0);
    check_eq("t1_issue_payload", issue_payload_o, 128'h1234_5678);
    issue_ack_i = 1;
    step();
    idle();
    check_eq("t1_still_issued0", sb_still_issued_o[0], 1);
    check_eq("t1_res_valid0", sb_res_valid_o[0], 0);
    check_eq("t1_issue_valid_after", issue_valid_o, 0);
    check_eq("t1_commit_valid_pre", commit_valid_o, 0);
    wb_valid_i = 1; wb_idx_i = 0; wb_data_i = 64'hDEAD;
    step();
    idle();
    check_eq("t2_res_valid0", sb_res_valid_o[0], 1);
    check_eq("t2_result0", sb_result_o[63:0], 64'hDEAD);
    check_eq("t2_commit_valid", commit_valid_o, 1);
    check_eq("t2_commit_result", commit_result_o, 64'hDEAD);
    check_eq("t2_commit_rd", commit_rd_o, 5);
    check_eq("t2_commit_payload", commit_payload_o, 128'h1234_5678);
    commit_ack_i = 1;
    step();
    idle();
    check_eq("t2_commit_valid_post", commit_valid_o, 0);
    check_eq("t2_commit_idx", commit_idx_o, 1);
    check_eq("t2_still_issued_post", sb_still_issued_o, 0);
    check_eq("t2_res_valid_post", sb_res_valid_o, 0);

    // fill, full back-pressure, no same-cycle bypass, wrap
    do_reset();
    for (int i = 0; i < NR; i++) begin
      decoded_valid_i = 1; decoded_rd_i = 5'(i + 1); decoded_payload_i = 128'(i);
      #1 check_eq($sformatf("t3_fill_ack%0d", i), decoded_ack_o, 1);
      step();
    end
    decoded_valid_i = 1;
    #1 check_eq("t3_full_ack", decoded_ack_o, 0);
    idle();
    issue_ack_i = 1;
    #1 check_eq("t3_issue_ptr", issue_pointer_o, 0);
    step();
    idle();
    wb_valid_i = 1; wb_idx_i = 0; wb_data_i = 64'hAA;
    step();
    idle();
    check_eq("t3_commit_valid", commit_valid_o, 1);
    decoded_valid_i = 1; decoded_rd_i = 31; commit_ack_i = 1;
    #1 check_eq("t3_ack_same_cycle", decoded_ack_o, 0);
    step();
    commit_ack_i = 0;
    #1 check_eq("t3_ack_next", decoded_ack_o, 1);
    step();
    idle();
    check_eq("t3_wrap_rd0", sb_rd_o[4:0], 31);
    check_eq("t3_wrap_still0", sb_still_issued_o[0], 0);
    check_eq("t3_commit_idx", commit_idx_o, 1);
    check_eq("t3_issue_ptr_after", issue_pointer_o, 1);
    decoded_valid_i = 1;
    #1 check_eq("t3_full_again", decoded_ack_o, 0);
    idle();

    // decode-time exception and rd=x0
    do_reset();
    decoded_valid_i = 1; decoded_rd_i = 3; decoded_ex_i = 1;
    step();
    idle();
    issue_ack_i = 1;
    #1 check_eq("t4_issue_ex", issue_ex_o, 1);
    step();
    idle();
    check_eq("t4_res_valid0", sb_res_valid_o[0], 1);
    check_eq("t4_commit_valid", commit_valid_o, 1);
    check_eq("t4_commit_ex", commit_ex_o, 1);
    check_eq("t4_still0", sb_still_issued_o[0], 1);
    commit_ack_i = 1;
    step();
    idle();
    decoded_valid_i = 1; decoded_rd_i = 0;
    step();
    idle();
    issue_ack_i = 1;
    step();
    idle();
    check_eq("t4_x0_still", sb_still_issued_o, 0);
    check_eq("t4_x0_issue_valid", issue_valid_o, 0);
    check_eq("t4_x0_res_valid", sb_res_valid_o, 0);

    // out-of-order writeback, in-order commit, stray writeback
    do_reset();
    decoded_valid_i = 1; decoded_rd_i = 7;
    step();
    decoded_rd_i = 8;
    step();
    idle();
    issue_ack_i = 1;
    step();
    step();
    idle();
    wb_valid_i = 1; wb_idx_i = 1; wb_data_i = 64'h22;
    step();
    idle();
    check_eq("t5_commit_hold", commit_valid_o, 0);
    check_eq("t5_res_valid", sb_res_valid_o, 8'b0000_0010);
    wb_valid_i = 1; wb_idx_i = 5; wb_data_i = 64'h55;
    step();
    idle();
    check_eq("t5_stray_res_valid", sb_res_valid_o, 8'b0000_0010);
    check_eq("t5_stray_result", sb_result_o[5*XL +: XL], 0);
    wb_valid_i = 1; wb_idx_i = 0; wb_data_i = 64'h11; wb_ex_i = 1;
    step();
    idle();
    check_eq("t5_commit_valid0", commit_valid_o, 1);
    check_eq("t5_commit_idx0", commit_idx_o, 0);
    check_eq("t5_commit_result0", commit_result_o, 64'h11);
    check_eq("t5_commit_ex0", commit_ex_o, 1);
    commit_ack_i = 1;
    step();
    idle();
    check_eq("t5_commit_valid1", commit_valid_o, 1);
    check_eq("t5_commit_idx1", commit_idx_o, 1);
    check_eq("t5_commit_result1", commit_result_o, 64'h22);
    check_eq("t5_commit_ex1", commit_ex_o, 0);
    check_eq("t5_commit_rd1", commit_rd_o, 8);
    commit_ack_i = 1;
    step();
    idle();
    check_eq("t5_drained", commit_valid_o, 0);

    // flush dominates everything in its cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      decoded_valid_i = 1; decoded_rd_i = 5'(i + 1);
      step();
    end
    idle();
    issue_ack_i = 1;
    step();
    step();
    idle();
    wb_valid_i = 1; wb_idx_i = 0; wb_data_i = 64'h77;
    step();
    idle();
    check_eq("t6_pre_commit_valid", commit_valid_o, 1);
    check_eq("t6_pre_still", sb_still_issued_o, 8'b0000_0011);
    flush_i = 1; decoded_valid_i = 1; commit_ack_i = 1;
    wb_valid_i = 1; wb_idx_i = 1; wb_data_i = 64'h99;
    #1 check_eq("t6_flush_ack", decoded_ack_o, 0);
    step();
    idle();
    check_eq("t6_issue_valid", issue_valid_o, 0);
    check_eq("t6_commit_valid", commit_valid_o, 0);
    check_eq("t6_still", sb_still_issued_o, 0);
    check_eq("t6_res_valid", sb_res_valid_o, 0);
    check_eq("t6_issue_ptr", issue_pointer_o, 0);
    check_eq("t6_commit_idx", commit_idx_o, 0);
    decoded_valid_i = 1; decoded_rd_i = 9;
    #1 check_eq("t6_post_ack", decoded_ack_o, 1);
    step();
    idle();
    check_eq("t6_post_issue_valid", issue_valid_o, 1);
    check_eq("t6_post_issue_ptr", issue_pointer_o, 0);

    // asynchronous reset mid-operation
    issue_ack_i = 1;
    step();
    idle();
    #2 rst_ni = 0;
    #1;
    check_eq("t7_async_still", sb_still_issued_o, 0);
    check_eq("t7_async_rd", sb_rd_o, 0);
    check_eq("t7_async_issue_ptr", issue_pointer_o, 0);
    rst_ni = 1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
